fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline buffer.
- Holds the PC and runs a request/acknowledge handshake with instruction memory.
- Presents {pc, instr} as a 64-bit word for the buffer to capture, plus a flush/bubble strobe.
- Handles stalls from the hazard unit, branch redirects, and discarding of in-flight stale fetches.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction-memory address.
- INSTR_WIDTH, 32, width of an instruction word.
- RESET_PC, 0, PC value loaded on reset.
- DATA_WIDTH, ADDR_WIDTH+INSTR_WIDTH (64), local, width of if_data; must equal the buffer's DATA_WIDTH.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous active-low reset.
- stall  in  1  hold the fetch outputs; from the hazard unit.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  ADDR_WIDTH  target address; bits [1:0] forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_WIDTH  fetch address; stable while imem_req is high and ack is not yet seen.
- imem_ack  in  1  read data valid this cycle; may arrive in the same cycle as req.
- imem_rdata  in  INSTR_WIDTH  instruction word, valid when imem_ack=1.
- if_data  out  DATA_WIDTH  {out_pc, out_instr}, feeds the buffer's data_in.
- if_flush  out  1  equals !out_valid; feeds the buffer's flush, inserting a bubble.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=FETCH, out_pc=0, out_instr=0, out_valid=0.
  - if_flush=1; imem_req forced to 0 while rst is low.
- Registers: pc, stale_addr, skid (INSTR_WIDTH), state, out_pc, out_instr, out_valid.
- States:
  - FETCH: req=1, addr=pc.
  - DROP: req=1, addr=stale_addr; discards one outstanding response.
  - HOLD: req=0; the fetched instruction sits in skid.
- Per-cycle priority: redirect > stall > ack.
- When redirect=1:
  - out_valid<=0 and pc<=redirect_pc.
  - FETCH & !ack: stale_addr<=pc, go to DROP.
  - FETCH & ack: response discarded, stay in FETCH.
  - HOLD: skid discarded, go to FETCH.
  - DROP: remain in DROP; pc takes the newest target.
- When stall=1 and redirect=0:
  - out_* hold their values, so the buffer recaptures an identical word.
  - FETCH & ack: skid<=rdata, go to HOLD.
  - FETCH & !ack: keep requesting the same address.
  - HOLD: stay in HOLD.
- FETCH, no stall, no redirect:
  - ack: out<={pc, rdata}, out_valid<=1, pc<=pc+4.
  - !ack: out_valid<=0 (bubble); pc unchanged.
- HOLD & !stall: out<={pc, skid}, out_valid<=1, pc<=pc+4, go to FETCH.
- DROP & ack: rdata discarded, go to FETCH; out_valid stays 0.
- PC arithmetic: pc+4 wraps modulo 2^ADDR_WIDTH; 0xFFFFFFFC+4 gives 0.
- Latency and throughput: one cycle from ack to if_data; throughput of 1 instruction/cycle when ack is held high.
- Reset mid-operation: everything returns to reset values immediately; any in-flight memory response after reset release is NOT tracked. The memory controller must drop pending requests on rst.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cycles [31:0] and perf_bubble_cycles [31:0].
  - perf_stall_cycles increments each cycle with stall=1.
  - perf_bubble_cycles increments each cycle with if_flush=1 after reset release.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - state encoding (FETCH=2'd0, DROP=2'd1, HOLD=2'd2);
  - PC_INCR=4;
  - default widths;
  - DATA_WIDTH derivation.
- One sub-module, fetch_pc_gen: next-PC mux (redirect_pc / pc+4 / hold) plus the pc register with async active-low reset.

Test Plan:
- Reset, then ack tied high with rdata=pc^0xA5A5A5A5:
  - if_data = {0x0, 0xA5A5A5A5}, {0x4, 0xA5A5A5A1}, ... on consecutive cycles;
  - if_flush=0 from the second cycle after reset release.
- Stall for 3 cycles while ack=1 at pc=0x8:
  - if_data held at its prior value and skid captures rdata;
  - after stall drops, if_data={0x8, skid} for one cycle, then pc=0xC is fetched.
- Redirect to 0x100 while in FETCH with ack=0:
  - state goes to DROP with imem_addr = old pc;
  - after 2 wait cycles, ack arrives and its data is discarded (if_flush=1 throughout);
  - the next fetch address is 0x100.
- redirect and stall asserted in the same cycle, redirect_pc=0x203:
  - redirect wins: pc=0x200 and if_flush=1 next cycle.
- PC at 0xFFFFFFFC with ack=1: next fetch address is 0x00000000.
- rst pulled low during DROP:
  - outputs zero immediately, imem_req=0;
  - after release, fetching restarts at RESET_PC.
  - With FETCH_PERF_CNT_EN defined: counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, PC step and widths.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam int PC_INCR           = 4;
    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_INSTR_WIDTH   = 32;

    function automatic int fetch_data_width(input int addr_w, input int instr_w);
        return addr_w + instr_w;
    endfunction

    localparam int DEF_DATA_WIDTH = fetch_data_width(DEF_ADDR_WIDTH, DEF_INSTR_WIDTH);

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC selection: word-aligned redirect target, pc+4, or hold.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_target,
    input  logic [ADDR_WIDTH-1:0] target_pc,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_target) begin
            pc_d = target_pc & ~ADDR_WIDTH'(3);
        end else if (advance) begin
            // Wraps naturally at the top of the address space.
            pc_d = pc_q + ADDR_WIDTH'(PC_INCR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID buffer. Optional FETCH_PERF_CNT_EN adds stall/bubble counters.
// state | meaning: FETCH | request at pc; DROP | request at stale_addr, discard its response;
//       HOLD  | no request, fetched instruction parked in skid during a stall
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic                              redirect,
    input  logic [ADDR_WIDTH-1:0]             redirect_pc,
    output logic                              imem_req,
    output logic [ADDR_WIDTH-1:0]             imem_addr,
    input  logic                              imem_ack,
    input  logic [INSTR_WIDTH-1:0]            imem_rdata,
    output logic [ADDR_WIDTH+INSTR_WIDTH-1:0] if_data,
    output logic                              if_flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_stall_cycles,
    output logic [31:0]                       perf_bubble_cycles
`endif
);

    localparam int DATA_WIDTH = fetch_data_width(ADDR_WIDTH, INSTR_WIDTH);

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  stale_addr_q, stale_addr_d;
    logic [INSTR_WIDTH-1:0] skid_q, skid_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic                   out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   pc_load;
    logic                   pc_adv;
    logic [DATA_WIDTH-1:0]  if_data_w;

    fetch_pc_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .load_target (pc_load),
        .target_pc   (redirect_pc),
        .advance     (pc_adv),
        .pc          (pc)
    );

    always_comb begin
        state_d      = state_q;
        stale_addr_d = stale_addr_q;
        skid_d       = skid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        out_valid_d  = out_valid_q;
        pc_load      = 1'b0;
        pc_adv       = 1'b0;

        if (redirect) begin
            out_valid_d = 1'b0;
            pc_load     = 1'b1;
            case (state_q)
                ST_FETCH: begin
                    if (!imem_ack) begin
                        stale_addr_d = pc;
                        state_d      = ST_DROP;
                    end
                end
                ST_HOLD: state_d = ST_FETCH;
                ST_DROP: state_d = ST_DROP;
                default: state_d = ST_FETCH;
            endcase
        end else if (stall) begin
            // Outputs hold so the buffer recaptures the same word; memory traffic still retires.
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        skid_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) state_d = ST_FETCH;
                end
                ST_HOLD: state_d = ST_HOLD;
                default: state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        out_pc_d    = pc;
                        out_instr_d = imem_rdata;
                        out_valid_d = 1'b1;
                        pc_adv      = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    out_pc_d    = pc;
                    out_instr_d = skid_q;
                    out_valid_d = 1'b1;
                    pc_adv      = 1'b1;
                    state_d     = ST_FETCH;
                end
                ST_DROP: begin
                    out_valid_d = 1'b0;
                    if (imem_ack) state_d = ST_FETCH;
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FETCH;
            stale_addr_q <= '0;
            skid_q       <= '0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stale_addr_q <= stale_addr_d;
            skid_q       <= skid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Gated by rst so no request escapes while the stage is held in reset.
    assign imem_req  = rst && (state_q != ST_HOLD);
    assign imem_addr = (state_q == ST_DROP) ? stale_addr_q : pc;
    assign if_data_w = {out_pc_q, out_instr_q};
    assign if_data   = if_data_w;
    assign if_flush  = !out_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (if_flush && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_stall_cycles  = stall_cnt_q;
    assign perf_bubble_cycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [63:0] if_data;
    logic        if_flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_bubble_cycles;
`endif

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_data     (if_data),
        .if_flush    (if_flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_bubble_cycles (perf_bubble_cycles)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: an architectural PC, an optional pending-discard address,
    // an optional parked instruction, and the word last presented downstream.
    logic [31:0] m_pc;
    bit          m_discard_pending;
    logic [31:0] m_discard_addr;
    bit          m_parked;
    logic [31:0] m_parked_instr;
    logic [31:0] m_out_pc;
    logic [31:0] m_out_instr;
    bit          m_out_valid;
    longint      m_stall_cnt;
    longint      m_bubble_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_addr();
        return m_discard_pending ? m_discard_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        m_discard_pending = 0;
        m_discard_addr = 32'h0;
        m_parked = 0;
        m_parked_instr = 32'h0;
        m_out_pc = 32'h0;
        m_out_instr = 32'h0;
        m_out_valid = 0;
        m_stall_cnt = 0;
        m_bubble_cnt = 0;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] tgt,
                              input bit ack, input logic [31:0] data);
        if (st) m_stall_cnt++;
        if (!m_out_valid) m_bubble_cnt++;
        if (rd) begin
            m_out_valid = 0;
            if (!m_discard_pending && !m_parked && !ack) begin
                m_discard_pending = 1;
                m_discard_addr = m_pc;
            end
            m_parked = 0;
            m_pc = {tgt[31:2], 2'b00};
        end else if (st) begin
            if (m_discard_pending) begin
                if (ack) m_discard_pending = 0;
            end else if (!m_parked && ack) begin
                m_parked = 1;
                m_parked_instr = data;
            end
        end else if (m_parked) begin
            m_out_pc = m_pc;
            m_out_instr = m_parked_instr;
            m_out_valid = 1;
            m_pc = m_pc + 32'd4;
            m_parked = 0;
        end else if (m_discard_pending) begin
            m_out_valid = 0;
            if (ack) m_discard_pending = 0;
        end else if (ack) begin
            m_out_pc = m_pc;
            m_out_instr = data;
            m_out_valid = 1;
            m_pc = m_pc + 32'd4;
        end else begin
            m_out_valid = 0;
        end
    endtask

    task automatic check_outputs();
        chk("imem_req", {63'b0, imem_req}, {63'b0, !m_parked});
        chk("imem_addr", {32'b0, imem_addr}, {32'b0, model_addr()});
        chk("if_data", if_data, {m_out_pc, m_out_instr});
        chk("if_flush", {63'b0, if_flush}, {63'b0, !m_out_valid});
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", {32'b0, perf_stall_cycles}, 64'(m_stall_cnt));
        chk("perf_bubble", {32'b0, perf_bubble_cycles}, 64'(m_bubble_cnt));
`endif
    endtask

    // One clock: drive inputs at the falling edge, advance the model at the rising
    // edge, compare at the next falling edge. rand_data chooses random rdata.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] tgt,
                         input bit ack, input bit rand_data);
        logic [31:0] data;
        data = rand_data ? $urandom : (model_addr() ^ 32'hA5A5_A5A5);
        stall = st;
        redirect = rd;
        redirect_pc = tgt;
        imem_ack = ack;
        imem_rdata = data;
        @(posedge clk);
        model_step(st, rd, tgt, ack, data);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [31:0] old_pc;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_req", {63'b0, imem_req}, 64'd0);
        chk("rst_if_data", if_data, 64'd0);
        chk("rst_flush", {63'b0, if_flush}, 64'd1);
        rst_n = 1'b1;

        // Streaming with ack held high.
        cycle(0, 0, 0, 1, 0);
        chk("stream_word0", if_data, 64'h0000_0000_A5A5_A5A5);
        chk("stream_flush0", {63'b0, if_flush}, 64'd0);
        cycle(0, 0, 0, 1, 0);
        chk("stream_word1", if_data, 64'h0000_0004_A5A5_A5A1);

        // Stall three cycles at pc=0x8 with ack high.
        chk("stall_pc", {32'b0, imem_addr}, 64'h8);
        repeat (3) cycle(1, 0, 0, 1, 0);
        chk("stall_hold", if_data, 64'h0000_0004_A5A5_A5A1);
        cycle(0, 0, 0, 0, 0);
        chk("skid_release", if_data, 64'h0000_0008_A5A5_A5AD);
        chk("after_skid_addr", {32'b0, imem_addr}, 64'hC);
        cycle(0, 0, 0, 1, 0);

        // Redirect to 0x100 while waiting for memory.
        old_pc = m_pc;
        cycle(0, 1, 32'h100, 0, 0);
        chk("drop_addr", {32'b0, imem_addr}, {32'b0, old_pc});
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("drop_flush", {63'b0, if_flush}, 64'd1);
        chk("drop_next_addr", {32'b0, imem_addr}, 64'h100);

        // Redirect and stall together: redirect wins, target aligned.
        cycle(1, 1, 32'h203, 1, 0);
        chk("redir_stall_addr", {32'b0, imem_addr}, 64'h200);
        chk("redir_stall_flush", {63'b0, if_flush}, 64'd1);

        // PC wrap at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFFE, 1, 0);
        chk("wrap_pc", {32'b0, imem_addr}, 64'hFFFF_FFFC);
        cycle(0, 0, 0, 1, 0);
        chk("wrap_word", if_data[63:32], 64'hFFFF_FFFC);
        chk("wrap_next", {32'b0, imem_addr}, 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 9) < 6, 1);
        end

        // Get into DROP, then reset mid-cycle.
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 32'h40, 0, 0);
        chk("pre_reset_dropping", {63'b0, m_discard_pending}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {63'b0, imem_req}, 64'd0);
        chk("mid_rst_if_data", if_data, 64'd0);
        chk("mid_rst_flush", {63'b0, if_flush}, 64'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_rst_perf_stall", {32'b0, perf_stall_cycles}, 64'd0);
        chk("mid_rst_perf_bubble", {32'b0, perf_bubble_cycles}, 64'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk("restart_addr", {32'b0, imem_addr}, 64'h0);
        cycle(0, 0, 0, 1, 0);
        chk("restart_word", if_data, 64'h0000_0000_A5A5_A5A5);
        repeat (4) cycle(0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
